enc_grant_decoder: RTL and testbench
====================================

Name: enc_grant_decoder

Overview:
Sequential counterpart of the team's 4-to-2 priority encoder (`enc`). It accepts an encoded request (index a, valid flag v) over a valid/ready handshake. It decodes the index back to a one-hot line and holds that line for HOLD cycles, then forces GAP idle cycles before the next request can be accepted. It sits downstream of the encoder and drives one-hot grant/select lines to the requesters.

Parameters:
N_OUT, 4, number of one-hot output lines
IDX_W, 2, index width; equals clog2(N_OUT)
HOLD, 3, cycles the one-hot output stays asserted per request; legal range 1 or more
GAP, 1, idle cycles after release before the next accept; legal range 0 or more

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
a  input  IDX_W  encoded index (a1,a0 from enc)
v  input  1  encoder valid flag; 0 means no requester is active
y  output  N_OUT  registered one-hot decoded output
busy  output  1  high in GRANT or GAP state
done  output  1  one-cycle pulse on the final cycle of y assertion
err  output  1  one-cycle pulse when an accepted index is >= N_OUT

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- States: IDLE, GRANT, GAP.
- Reset (rst=1 at an edge):
  - state goes to IDLE; y=0, done=0, err=0, busy=0; counters go to 0.
  - in_ready = (state==IDLE) & ~rst, so in_ready is 0 while rst is high.
- Accept: an accept occurs on an edge where in_valid & in_ready.
  - With v=1: latch a; go to GRANT. y = 1<<a appears in the cycle after the accept (latency 1).
  - With v=0: the request is consumed and dropped. State stays IDLE, y stays 0, no done.
- GRANT:
  - y is held at the latched one-hot value for exactly HOLD cycles; in_ready=0; busy=1.
  - done=1 during the last GRANT cycle only.
  - Next state is GAP if GAP>0, otherwise IDLE.
- GAP:
  - y=0, in_ready=0, busy=1 for exactly GAP cycles, then IDLE.
- Index out of range (a >= N_OUT, possible only when N_OUT is not a power of 2):
  - err pulses in the cycle after the accept.
  - The FSM still runs GRANT/GAP timing with y=0, and done still pulses.
- Throughput: one request per HOLD+GAP+1 cycles. in_valid held high is accepted on the first IDLE cycle.
- in_valid and a are sampled only on accept; changes during GRANT/GAP are ignored.
- Reset mid-GRANT/GAP: abort takes effect on the next edge. y=0, no done pulse, and the latched request is discarded.
- Counter: a single down-counter of width clog2(max(HOLD,GAP)+1). Loaded with HOLD-1 or GAP-1 on state entry; the state ends when it reaches 0.
- All outputs are registered except in_ready, which is combinational from state and rst.

Decomposition:
- Shared package enc_pkg holds:
  - the state typedef {IDLE, GRANT, GAP};
  - localparam IDX_W=$clog2(N_OUT);
  - a one-hot decode function, shared with the encoder testbench as the reference model.
- One sub-module is natural: dec_hold_cnt, a loadable down-counter with a zero flag, reused for both HOLD and GAP.

Test Plan (HOLD=3, GAP=1, N_OUT=4):
1. rst=1 for 2 cycles with in_valid=1 -> y=0000, done=0, busy=0, in_ready=0 throughout; in_ready=1 the first cycle after rst drops.
2. Accept a=01, v=1 at cycle t -> y=0010 in cycles t+1..t+3; done=1 only in t+3; y=0000 and busy=1 in t+4; in_ready=1 in t+5.
3. Accept a=11, v=0 -> y stays 0000, busy stays 0, in_ready stays 1, no done.
4. in_valid held high with a=11 (accepted at t), then a=00 presented from t+1 -> second accept occurs at t+5; y=1000 for t+1..t+3, y=0001 for t+6..t+8.
5. Accept a=10 at t, rst=1 at t+2 -> y=0000 from t+3, state IDLE, no done pulse; a new accept after reset produces 0100 normally.
6. enc drives the block directly with inputs 0000, 0001, 0010, 0110, 1000, 1111 -> y = 0000 (v=0, dropped), 0001, 0010, 0100, 1000, 1000 respectively, each held for 3 cycles.

Source files
------------

// File: rtl/enc_grant_decoder_pkg.sv
// enc_pkg: definitions shared by the enc / enc_grant_decoder family.
//   state_t     - grant decoder FSM states
//   ENC_N_OUT   - default number of one-hot lines (4-to-2 encoder)
//   ENC_IDX_W   - default index width, $clog2(ENC_N_OUT)
//   onehot_dec  - index -> one-hot decode; out-of-range indices give all zeros
package enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

    localparam int unsigned ENC_N_OUT = 4;
    localparam int unsigned ENC_IDX_W = $clog2(ENC_N_OUT);

    // Widest one-hot vector onehot_dec can produce; callers truncate to N_OUT.
    localparam int unsigned ONEHOT_MAX = 32;

    function automatic logic [ONEHOT_MAX-1:0] onehot_dec(input int unsigned idx,
                                                         input int unsigned n_out);
        logic [ONEHOT_MAX-1:0] res;
        res = '0;
        if (idx < n_out && idx < ONEHOT_MAX) begin
            res[idx] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/enc_grant_decoder_if.sv
// Request/grant bundle between the encoder side and enc_grant_decoder.
//   in_valid, a, v            request from the encoder (master drives)
//   in_ready                  decoder can accept this cycle
//   y, busy, done, err        decoder status / one-hot grant lines
// Modports: master = request producer, slave = enc_grant_decoder.
interface enc_grant_decoder_if #(
    parameter int unsigned N_OUT = 4,
    parameter int unsigned IDX_W = $clog2(N_OUT)
) ();
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] a;
    logic             v;
    logic [N_OUT-1:0] y;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output in_valid, a, v,
        input  in_ready, y, busy, done, err
    );

    modport slave (
        input  in_valid, a, v,
        output in_ready, y, busy, done, err
    );
endinterface

// File: rtl/enc_grant_decoder_dec_hold_cnt.sv
// dec_hold_cnt: loadable down-counter with a zero flag, used by the grant
// decoder for both the HOLD and the GAP phase.
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   load      - load load_val (takes priority over dec)
//   load_val  - value to load
//   dec       - decrement; saturates at zero
//   cnt       - current count
//   zero      - cnt == 0
module dec_hold_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
endmodule

// File: rtl/enc_grant_decoder.sv
// enc_grant_decoder: takes an encoded request (index a, valid flag v) over a
// valid/ready handshake, drives the decoded one-hot line on y for HOLD cycles,
// then idles GAP cycles before the next accept.
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset; aborts any grant in progress
//   bus.slave - in_valid/a/v in; in_ready (combinational), y, busy, done,
//               err (all registered) out
module enc_grant_decoder
    import enc_pkg::*;
#(
    parameter int unsigned N_OUT = 4,
    parameter int unsigned IDX_W = $clog2(N_OUT),
    parameter int unsigned HOLD  = 3,
    parameter int unsigned GAP   = 1
) (
    input  logic clk,
    input  logic rst,
    enc_grant_decoder_if.slave bus
);
    localparam int unsigned CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    state_t           state;
    logic [N_OUT-1:0] y_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             take;
    logic [N_OUT-1:0] dec_line;
    logic             idx_bad;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    assign idx      = bus.a;
    assign accept   = bus.in_valid & bus.in_ready;
    // v=0 accepts are consumed but never start a grant.
    assign take     = accept & bus.v;
    assign dec_line = N_OUT'(onehot_dec(32'(idx), N_OUT));
    assign idx_bad  = (32'(idx) >= N_OUT);

    assign bus.in_ready = (state == ST_IDLE) & ~rst;
    assign bus.y        = y_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = HOLD_LD;
        cnt_dec  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (take) begin
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LD;
                end
            end
            ST_GRANT: begin
                if (cnt_zero) begin
                    cnt_load = (GAP > 0);
                    cnt_val  = GAP_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GAP: begin
                cnt_dec = 1'b1;
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    dec_hold_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // done is registered, so it is raised on the edge entering the last GRANT
    // cycle: at accept when HOLD==1, otherwise when the count steps 1 -> 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            y_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (take) begin
                        state  <= ST_GRANT;
                        busy_q <= 1'b1;
                        y_q    <= dec_line;
                        err_q  <= idx_bad;
                        done_q <= (HOLD == 1);
                    end
                end
                ST_GRANT: begin
                    if (cnt_zero) begin
                        y_q <= '0;
                        if (GAP > 0) begin
                            state <= ST_GAP;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        done_q <= (cnt == CNT_W'(1));
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    y_q    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_enc_grant_decoder.sv
// Bench for enc_grant_decoder (N_OUT=4, HOLD=3, GAP=1). A transaction-level
// model records, per future cycle, what y/busy/done/err must be and from which
// cycle the block is free again; each scenario task compares the DUT against it.
module tb_enc_grant_decoder;
    localparam int unsigned N     = 4;
    localparam int unsigned HOLD  = 3;
    localparam int unsigned GAP   = 1;
    localparam int unsigned DEPTH = 2048;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    enc_grant_decoder_if #(.N_OUT(N), .IDX_W(2)) bus ();

    enc_grant_decoder #(
        .N_OUT (N),
        .IDX_W (2),
        .HOLD  (HOLD),
        .GAP   (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned cyc;
    int unsigned free_at;
    int unsigned n_cmp;
    int unsigned n_bad;

    logic [3:0] exp_y    [DEPTH];
    logic       exp_busy [DEPTH];
    logic       exp_done [DEPTH];
    logic       exp_err  [DEPTH];

    function automatic logic [7:0] got_vec();
        return {bus.y, bus.busy, bus.done, bus.err, bus.in_ready};
    endfunction

    function automatic logic [7:0] want_vec();
        logic rdy;
        rdy = (rst == 1'b0) && (cyc >= free_at);
        return {exp_y[cyc], exp_busy[cyc], exp_done[cyc], exp_err[cyc], rdy};
    endfunction

    task automatic drive(input bit r, input bit iv, input int unsigned ia, input bit vv);
        rst          = r;
        bus.in_valid = iv;
        bus.a        = 2'(ia);
        bus.v        = vv;
        #1;
    endtask

    // Advance the model with the inputs present this cycle, then clock once.
    task automatic step();
        if (cyc + HOLD + GAP + 2 >= DEPTH) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, DEPTH);
            $fatal(1, "cycle budget exceeded");
        end
        if (rst) begin
            for (int unsigned k = 1; k <= HOLD + GAP + 1; k++) begin
                exp_y[cyc+k]    = '0;
                exp_busy[cyc+k] = 1'b0;
                exp_done[cyc+k] = 1'b0;
                exp_err[cyc+k]  = 1'b0;
            end
            free_at = cyc + 1;
        end else if (bus.in_valid && cyc >= free_at && bus.v) begin
            for (int unsigned k = 1; k <= HOLD; k++)
                exp_y[cyc+k] = (32'(bus.a) < N) ? (4'(1) << bus.a) : 4'b0000;
            for (int unsigned k = 1; k <= HOLD + GAP; k++)
                exp_busy[cyc+k] = 1'b1;
            exp_done[cyc+HOLD] = 1'b1;
            exp_err[cyc+1]     = (32'(bus.a) >= N);
            free_at            = cyc + HOLD + GAP + 1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1);
        step();
        drive(1, 1, 1, 1);
        n_cmp++;
        if (got_vec() !== want_vec()) begin
            n_bad++;
            $display("FAIL reset_hold cyc=%0d got y,busy,done,err,rdy=%b required=%b", cyc, got_vec(), want_vec());
        end
        step();
        drive(0, 0, 0, 0);
        n_cmp++;
        if (got_vec() !== want_vec()) begin
            n_bad++;
            $display("FAIL reset_release cyc=%0d got y,busy,done,err,rdy=%b required=%b", cyc, got_vec(), want_vec());
        end
        step();
    endtask

    task automatic test_single();
        for (int i = 0; i < 7; i++) begin
            drive(0, i == 0, 1, 1);
            n_cmp++;
            if (got_vec() !== want_vec()) begin
                n_bad++;
                $display("FAIL single cyc=%0d got y,busy,done,err,rdy=%b required=%b", cyc, got_vec(), want_vec());
            end
            step();
        end
    endtask

    task automatic test_drop();
        for (int i = 0; i < 4; i++) begin
            drive(0, i == 0, 3, 0);
            n_cmp++;
            if (got_vec() !== want_vec()) begin
                n_bad++;
                $display("FAIL drop cyc=%0d got y,busy,done,err,rdy=%b required=%b", cyc, got_vec(), want_vec());
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 15; i++) begin
            drive(0, i < 9, (i == 0) ? 3 : 0, 1);
            n_cmp++;
            if (got_vec() !== want_vec()) begin
                n_bad++;
                $display("FAIL back_to_back cyc=%0d got y,busy,done,err,rdy=%b required=%b", cyc, got_vec(), want_vec());
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 12; i++) begin
            drive(i == 2, (i == 0) || (i == 5), 2, 1);
            n_cmp++;
            if (got_vec() !== want_vec()) begin
                n_bad++;
                $display("FAIL reset_mid cyc=%0d got y,busy,done,err,rdy=%b required=%b", cyc, got_vec(), want_vec());
            end
            step();
        end
    endtask

    task automatic test_enc_chain();
        logic [3:0] pats [6];
        logic [3:0] req;
        int unsigned ea;
        bit ev;
        pats = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1000, 4'b1111};
        foreach (pats[p]) begin
            req = pats[p];
            ev  = (req != 4'b0000);
            ea  = 0;
            for (int b = 0; b < 4; b++)
                if (req[b]) ea = b;
            for (int i = 0; i < 6; i++) begin
                drive(0, i == 0, ea, ev);
                n_cmp++;
                if (got_vec() !== want_vec()) begin
                    n_bad++;
                    $display("FAIL enc_chain req=%b cyc=%0d got y,busy,done,err,rdy=%b required=%b", req, cyc, got_vec(), want_vec());
                end
                step();
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3), $urandom_range(0, 3) != 0);
            n_cmp++;
            if (got_vec() !== want_vec()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got y,busy,done,err,rdy=%b required=%b", cyc, got_vec(), want_vec());
            end
            step();
        end
    endtask

    initial begin
        cyc     = 0;
        free_at = 0;
        n_cmp   = 0;
        n_bad   = 0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            exp_y[k]    = '0;
            exp_busy[k] = 1'b0;
            exp_done[k] = 1'b0;
            exp_err[k]  = 1'b0;
        end
        test_reset();
        test_single();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_enc_chain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
